dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the byte-address width; word index is addr[ADDR_W-1:2].
REQ-002 Parameter MAX_WAIT, default 4, SHALL set the consecutive debug-wait cycles that force a debug grant; range 1..15.
REQ-003 Ports SHALL be exactly as follows.
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Reset, synchronous, active-high.
- cpu_req  in  1  MEM-stage access request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  MEM-stage byte address.
- cpu_wdata  in  32  Store data.
- cpu_rdata  out  32  Load data, combinational from mem_rdata.
- cpu_stall  out  1  Freeze pipeline, combinational.
- dbg_req  in  1  Debug/loader request, level, held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  Debug byte address.
- dbg_wdata  in  32  Debug write data.
- dbg_ack  out  1  One-cycle completion pulse, registered.
- dbg_rdata  out  32  Debug read data, registered, valid with dbg_ack.
- mem_addr  out  ADDR_W  Shared address to DMEM read and write address inputs.
- mem_we  out  1  DMEM MemWrite.
- mem_re  out  1  DMEM MemRead.
- mem_wdata  out  32  DMEM write data.
- mem_rdata  in  32  DMEM combinational read data.

Function
REQ-004 The block SHALL grant at most one requester per cycle; the winner drives mem_addr, mem_we (= winner's we), mem_re (= ~we) and mem_wdata combinationally in the grant cycle.
REQ-005 With no grant, mem_we and mem_re SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-006 The debug FSM SHALL have two states: D_IDLE and D_ACK.
- D_IDLE -> D_ACK on a debug grant.
- D_ACK -> D_IDLE unconditionally after one cycle.
- dbg_ack = (state == D_ACK).
REQ-007 Debug SHALL NOT be granted while in D_ACK, so a held dbg_req is not re-served in the ack cycle.
REQ-008 Priority SHALL be as follows.
- CPU wins by default.
- Debug wins when wait_cnt >= MAX_WAIT.
- Debug wins when cpu_req = 0.
REQ-009 wait_cnt (4 bits) SHALL behave as follows.
- Increments, saturating at 15, in each cycle dbg_req = 1, the FSM is in D_IDLE and debug is not granted.
- Clears on a debug grant.
- Clears when dbg_req = 0.
REQ-010 cpu_stall SHALL equal cpu_req & ~cpu_grant.
REQ-011 A stalled CPU request SHALL be granted in the next cycle, because wait_cnt is 0 after any debug grant.
REQ-012 On a debug read grant, mem_rdata SHALL be captured into dbg_rdata at the clock edge; dbg_rdata SHALL hold its value otherwise.
REQ-013 On a debug write grant, dbg_rdata SHALL be unchanged.
REQ-014 cpu_rdata SHALL equal mem_rdata at all times; it is meaningful only in a cycle where the CPU is granted a load.
REQ-015 A misaligned address (addr[1:0] != 0) SHALL be passed through unmodified; DMEM ignores the low bits.
REQ-016 When cpu_req and dbg_req are both high, wait_cnt = MAX_WAIT-1, and debug loses, wait_cnt SHALL reach MAX_WAIT and debug SHALL win the following cycle.

Reset
REQ-017 While rst = 1 at a clock edge, the following registers SHALL be cleared: FSM state to D_IDLE, wait_cnt to 0, dbg_rdata to 0, and (if compiled) stall_cnt to 0.
REQ-018 Reset SHALL force dbg_ack = 0 in the following cycle.
REQ-019 A debug grant in the reset cycle SHALL be abandoned with no ack; the requester re-issues after reset.
REQ-020 Combinational outputs during reset SHALL follow REQ-004 and REQ-010; the memory write is not blocked by the arbiter.

Configuration
REQ-021 With macro DMEM_ARB_STALL_CNT_EN defined, the block SHALL add output stall_cnt [15:0].
- Increments each cycle cpu_stall = 1.
- Saturates at 16'hFFFF.
- Cleared by reset.
REQ-022 Without DMEM_ARB_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 Reset sequence SHALL be checked.
- Stimulus: rst = 1 for 2 cycles, then release with all requests low.
- Required: dbg_ack = 0, dbg_rdata = 0, mem_we = 0, mem_re = 0, cpu_stall = 0.
REQ-024 Lone CPU access SHALL be checked.
- Stimulus: cpu_req = 1, cpu_we = 1, cpu_addr = 7'h08, cpu_wdata = 32'hDEADBEEF; then a load from 7'h08.
- Required: mem_we = 1 in the store cycle; cpu_rdata = 32'hDEADBEEF in the load cycle; cpu_stall = 0 throughout.
REQ-025 Debug read SHALL be checked.
- Stimulus: dbg_req = 1, dbg_we = 0, dbg_addr = 7'h08, cpu idle.
- Required: grant in cycle 0; dbg_ack = 1 and dbg_rdata = 32'hDEADBEEF in cycle 1 only; no second grant while req is still held in cycle 1.
REQ-026 Contention with MAX_WAIT = 4 SHALL be checked.
- Stimulus: cpu_req = 1 continuously and dbg_req = 1 from cycle 0.
- Required: CPU granted in cycles 0-3; debug granted in cycle 4 with cpu_stall = 1; CPU granted in cycle 5; dbg_ack = 1 in cycle 5.
REQ-027 Reset during debug grant SHALL be checked.
- Stimulus: assert rst in the debug grant cycle.
- Required: dbg_ack = 0 in the next cycle; wait_cnt = 0.
REQ-028 With DMEM_ARB_STALL_CNT_EN defined, the stall counter SHALL be checked.
- Stimulus: the REQ-026 sequence.
- Required: stall_cnt = 1 after cycle 4.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM
// stage and a debug/loader port. The CPU wins by default. Debug wins when
// the CPU is idle, or once it has waited MAX_WAIT consecutive cycles.
// Debug accesses complete with a registered one-cycle ack and read data.
// Optional feature: define DMEM_ARB_STALL_CNT_EN to add a saturating
// 16-bit cpu_stall cycle counter on output stall_cnt.
module dmem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_wdata,
`ifdef DMEM_ARB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic {D_IDLE = 1'b0, D_ACK = 1'b1} dstate_t;

  dstate_t    state;
  logic [3:0] wait_cnt;
  logic       dbg_elig;
  logic       dbg_grant;
  logic       cpu_grant;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Grant decision: debug is never eligible in its ack cycle, so a
  // still-held request is not served twice.
  always_comb begin
    dbg_elig  = dbg_req & (state == D_IDLE);
    dbg_grant = dbg_elig & (~cpu_req | (wait_cnt >= MAX_WAIT_C));
    cpu_grant = cpu_req & ~dbg_grant;
    cpu_stall = cpu_req & ~cpu_grant;
  end

  // Memory port mux: the winner drives the memory; idle drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_rdata = mem_rdata;

  // Debug FSM with registered ack; a grant in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= D_IDLE;
      dbg_ack <= 1'b0;
    end else begin
      case (state)
        D_IDLE: begin
          if (dbg_grant) begin
            state   <= D_ACK;
            dbg_ack <= 1'b1;
          end else begin
            dbg_ack <= 1'b0;
          end
        end
        default: begin
          state   <= D_IDLE;
          dbg_ack <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive debug wait cycles; reaching MAX_WAIT forces a debug grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (dbg_grant || !dbg_req) begin
      wait_cnt <= 4'd0;
    end else if (state == D_IDLE) begin
      wait_cnt <= sat_inc4(wait_cnt);
    end
  end

  // Debug read data is captured on a read grant and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata <= 32'd0;
    end else if (dbg_grant && !dbg_we) begin
      dbg_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STALL_CNT_EN
  // Count CPU stall cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (cpu_stall) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DMEM attached.
// Inputs change 1ns after the rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_ack;
  logic [31:0]       dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_re;
  logic [31:0]       mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] dmem [32];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
`ifdef DMEM_ARB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .mem_rdata (mem_rdata)
  );

  // Behavioural DMEM: combinational read, write on the rising edge.
  assign mem_rdata = dmem[mem_addr[ADDR_W-1:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[ADDR_W-1:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dmem[i] = 32'd0;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

    // Reset held for two cycles, then released with requests low
    next_cycle();
    next_cycle();
    rst = 1'b0;
    mid();
    chk("rst_ack",   dbg_ack,   0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_we",    mem_we,    0);
    chk("rst_re",    mem_re,    0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_addr",  mem_addr,  0);

    // Lone CPU store then load
    next_cycle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'h08; cpu_wdata = 32'hDEADBEEF;
    mid();
    chk("st_we",    mem_we,    1);
    chk("st_re",    mem_re,    0);
    chk("st_addr",  mem_addr,  7'h08);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_stall", cpu_stall, 0);
    next_cycle();
    cpu_we = 0;
    mid();
    chk("ld_re",    mem_re,    1);
    chk("ld_we",    mem_we,    0);
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_stall", cpu_stall, 0);

    // Debug read with CPU idle; request held through the ack cycle
    next_cycle();
    cpu_req = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'h08;
    mid();
    chk("dr_c0_re",   mem_re,   1);
    chk("dr_c0_addr", mem_addr, 7'h08);
    chk("dr_c0_ack",  dbg_ack,  0);
    next_cycle();
    mid();
    chk("dr_c1_ack",   dbg_ack,   1);
    chk("dr_c1_rdata", dbg_rdata, 32'hDEADBEEF);
    chk("dr_c1_re",    mem_re,    0);
    chk("dr_c1_we",    mem_we,    0);
    next_cycle();
    dbg_req = 0;
    mid();
    chk("dr_c2_ack",   dbg_ack,   0);
    chk("dr_c2_rdata", dbg_rdata, 32'hDEADBEEF);

    // Debug write: memory written, dbg_rdata untouched
    next_cycle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 7'h10; dbg_wdata = 32'h12345678;
    mid();
    chk("dw_we",    mem_we,    1);
    chk("dw_re",    mem_re,    0);
    chk("dw_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    dbg_req = 0; dbg_we = 0;
    mid();
    chk("dw_ack",   dbg_ack,   1);
    chk("dw_rdata", dbg_rdata, 32'hDEADBEEF);

    // Misaligned CPU load passes the address through unchanged
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'h13;
    mid();
    chk("mis_addr",  mem_addr,  7'h13);
    chk("mis_rdata", cpu_rdata, 32'h12345678);

    // Contention: CPU holds cycles 0-3, debug forced in cycle 4
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'h08;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'h10;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("ct_c%0d_stall", c), cpu_stall, 0);
      chk($sformatf("ct_c%0d_addr", c),  mem_addr,  7'h08);
      next_cycle();
    end
    mid();
    chk("ct_c4_stall", cpu_stall, 1);
    chk("ct_c4_addr",  mem_addr,  7'h10);
    chk("ct_c4_re",    mem_re,    1);
    next_cycle();
    mid();
    chk("ct_c5_stall", cpu_stall, 0);
    chk("ct_c5_addr",  mem_addr,  7'h08);
    chk("ct_c5_ack",   dbg_ack,   1);
    chk("ct_c5_rdata", dbg_rdata, 32'h12345678);
`ifdef DMEM_ARB_STALL_CNT_EN
    chk("ct_stall_cnt", stall_cnt, 1);
`endif

    // Dropping dbg_req restarts the wait count from zero
    next_cycle();
    dbg_req = 0;
    next_cycle();
    dbg_req = 1; dbg_addr = 7'h08;
    for (int c = 0; c < 2; c++) next_cycle();
    dbg_req = 0;
    mid();
    chk("wc_clear", dut.wait_cnt, 2);
    next_cycle();
    dbg_req = 1;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("wc_c%0d_stall", c), cpu_stall, 0);
      next_cycle();
    end
    mid();
    chk("wc_c4_stall", cpu_stall, 1);

    // Reset asserted in a debug grant cycle: grant abandoned, no ack
    next_cycle();
    cpu_req = 0; dbg_req = 0;
    next_cycle();
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'h08; rst = 1;
    mid();
    chk("rg_re", mem_re, 1);
    next_cycle();
    rst = 0; dbg_req = 0;
    mid();
    chk("rg_ack",   dbg_ack,      0);
    chk("rg_wait",  dut.wait_cnt, 0);
    chk("rg_rdata", dbg_rdata,    0);

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
